// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the spiking-network receive path.
//   DEF_CNT_W / DEF_WIN_W : default widths of the count and window-length paths
//   dec_state_e           : decoder FSM states (DEC_IDLE, DEC_RUN)
//   sat_max()             : all-ones saturation limit for a counter of width w
//   SAT_MAX               : saturation limit at the default count width
// ---------------------------------------------------------------------------
package snn_pkg;

  localparam int unsigned DEF_CNT_W = 8;
  localparam int unsigned DEF_WIN_W = 8;

  typedef enum logic [0:0] {
    DEC_IDLE = 1'b0,
    DEC_RUN  = 1'b1
  } dec_state_e;

  // Largest value a w-bit counter can hold (valid for w up to 32).
  function automatic logic [31:0] sat_max(input int unsigned w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam logic [DEF_CNT_W-1:0] SAT_MAX = DEF_CNT_W'(sat_max(DEF_CNT_W));

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Clear has priority over increment.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : synchronous clear to zero
//   i_inc      : increment by one (ignored once at the maximum)
//   o_q        : current count
//   o_at_max   : count equals the saturation limit
// ---------------------------------------------------------------------------
module sat_counter
  import snn_pkg::*;
#(
  parameter int unsigned W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_q,
  output logic         o_at_max
);

  localparam logic [W-1:0] MAX = W'(sat_max(W));

  logic [W-1:0] r_q;

  // NOTE: state is updated with non-blocking assignments so every flop in the
  // design samples the same pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_inc && (r_q != MAX)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign o_q      = r_q;
  assign o_at_max = (r_q == MAX);

endmodule

// File: rtl/spike_rate_decoder.sv
// ---------------------------------------------------------------------------
// spike_rate_decoder
// Turns a single-bit spike train back into numbers: the number of spike
// onsets in each programmable window, and the interval between successive
// onsets. A level held high for several cycles counts as one spike.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : decoder enable (gates both the window FSM and ISI path)
//   spike_in    : spike stream, synchronous to clk
//   window_len  : window length in cycles; 0 keeps the window path idle
//   rate_out    : onset count of the last completed window (saturating)
//   rate_valid  : one-cycle pulse when rate_out updates
//   isi_out     : cycles between the last two onsets (saturating)
//   isi_valid   : one-cycle pulse when isi_out updates
//   busy        : high while a window is being counted
// ---------------------------------------------------------------------------
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned WIN_W = DEF_WIN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] window_len,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  output logic [CNT_W-1:0] isi_out,
  output logic             isi_valid,
  output logic             busy
);

  dec_state_e       r_state;
  dec_state_e       w_state_nxt;

  logic             r_spike_q;
  logic             w_onset;

  logic [WIN_W-1:0] r_win_len;
  logic [WIN_W-1:0] w_win_cnt;
  logic             w_win_last;
  logic             w_unused_win_max;

  logic [CNT_W-1:0] w_spk_cnt;
  logic             w_spk_at_max;
  logic [CNT_W-1:0] w_rate_nxt;

  logic [CNT_W-1:0] w_isi_cnt;
  logic             w_isi_at_max;
  logic [CNT_W-1:0] w_isi_nxt;

  logic             w_start;   // IDLE -> RUN this cycle
  logic             w_close;   // last cycle of a window
  logic             w_abort;   // en dropped while running
  logic             w_run;     // counting cycle inside a window

  logic [CNT_W-1:0] r_rate_out;
  logic             r_rate_valid;
  logic [CNT_W-1:0] r_isi_out;
  logic             r_isi_valid;
  logic             r_armed;

  // Rising edge of the spike level; a held level yields a single onset.
  assign w_onset = spike_in & ~r_spike_q;

  // r_win_len is never 0 while running, so the subtraction cannot wrap.
  assign w_win_last = (w_win_cnt == (r_win_len - WIN_W'(1)));

  // ---------------------------------------------------------------------
  // Window FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DEC_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_close     = 1'b0;
    w_abort     = 1'b0;
    w_run       = 1'b0;
    case (r_state)
      DEC_IDLE: begin
        if (en && (window_len != '0)) begin
          w_state_nxt = DEC_RUN;
          w_start     = 1'b1;
        end
      end
      DEC_RUN: begin
        if (!en) begin
          // Partial window is thrown away without a rate pulse.
          w_state_nxt = DEC_IDLE;
          w_abort     = 1'b1;
        end else begin
          w_run = 1'b1;
          if (w_win_last) begin
            w_close = 1'b1;
            // window_len is re-sampled here; 0 ends the run.
            if (window_len == '0) begin
              w_state_nxt = DEC_IDLE;
            end
          end
        end
      end
      default: begin
        w_state_nxt = DEC_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------
  // Window position. It never reaches all-ones because it restarts at
  // r_win_len - 1, so the saturation flag is not needed here.
  sat_counter #(.W(WIN_W)) u_win_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_start | w_close | w_abort),
    .i_inc    (w_run),
    .o_q      (w_win_cnt),
    .o_at_max (w_unused_win_max)
  );

  // Onsets in the current window. On the closing cycle the clear wins, so an
  // onset there is folded into w_rate_nxt instead of the next window.
  sat_counter #(.W(CNT_W)) u_spk_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_start | w_close | w_abort),
    .i_inc    (w_run & w_onset),
    .o_q      (w_spk_cnt),
    .o_at_max (w_spk_at_max)
  );

  // Cycles since the last onset; runs only once armed, restarts on each
  // onset and is held at zero while disabled.
  sat_counter #(.W(CNT_W)) u_isi_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (~en | w_onset),
    .i_inc    (en & r_armed),
    .o_q      (w_isi_cnt),
    .o_at_max (w_isi_at_max)
  );

  assign w_rate_nxt = (w_onset && !w_spk_at_max) ? (w_spk_cnt + CNT_W'(1)) : w_spk_cnt;
  // The onset cycle itself is part of the interval, hence the +1.
  assign w_isi_nxt  = w_isi_at_max ? w_isi_cnt : (w_isi_cnt + CNT_W'(1));

  // ---------------------------------------------------------------------
  // Registered outputs and bookkeeping
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spike_q    <= 1'b0;
      r_win_len    <= '0;
      r_rate_out   <= '0;
      r_rate_valid <= 1'b0;
      r_isi_out    <= '0;
      r_isi_valid  <= 1'b0;
      r_armed      <= 1'b0;
    end else begin
      r_spike_q <= spike_in;

      // Length changes during a window only apply from the next window.
      if (w_start || w_close) begin
        r_win_len <= window_len;
      end

      r_rate_valid <= w_close;
      if (w_close) begin
        r_rate_out <= w_rate_nxt;
      end

      r_isi_valid <= en & w_onset & r_armed;
      if (!en) begin
        r_armed <= 1'b0;
      end else if (w_onset) begin
        r_armed <= 1'b1;
        if (r_armed) begin
          r_isi_out <= w_isi_nxt;
        end
      end
    end
  end

  assign rate_out   = r_rate_out;
  assign rate_valid = r_rate_valid;
  assign isi_out    = r_isi_out;
  assign isi_valid  = r_isi_valid;
  assign busy       = (r_state == DEC_RUN);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// ---------------------------------------------------------------------------
// tb_spike_rate_decoder
// Drives a default-width decoder and a CNT_W=7 copy. Expected rate/ISI
// results, tagged with the cycle they must appear in, are queued as stimulus
// is applied; negedge monitors pop and compare whenever a valid pulse shows.
// ---------------------------------------------------------------------------
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       en7;
  logic       spike_in;
  logic [7:0] window_len;

  logic [7:0] rate_out, isi_out;
  logic       rate_valid, isi_valid, busy;
  logic [6:0] rate_out7, isi_out7;
  logic       rate_valid7, isi_valid7, busy7;

  spike_rate_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .spike_in   (spike_in),
    .window_len (window_len),
    .rate_out   (rate_out),
    .rate_valid (rate_valid),
    .isi_out    (isi_out),
    .isi_valid  (isi_valid),
    .busy       (busy)
  );

  spike_rate_decoder #(.CNT_W(7), .WIN_W(8)) dut7 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en7),
    .spike_in   (spike_in),
    .window_len (window_len),
    .rate_out   (rate_out7),
    .rate_valid (rate_valid7),
    .isi_out    (isi_out7),
    .isi_valid  (isi_valid7),
    .busy       (busy7)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t rate_q[$];
  exp_t rate7_q[$];
  exp_t isi_q[$];
  bit   isi_mon = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rate_valid === 1'b1) begin
      if (rate_q.size() == 0) begin
        check("rate_valid_unexpected", 32'(rate_valid), 32'd0);
      end else begin
        e = rate_q.pop_front();
        check("rate_out", 32'(rate_out), e.val);
        check("rate_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rate_valid7 === 1'b1) begin
      if (rate7_q.size() == 0) begin
        check("rate7_valid_unexpected", 32'(rate_valid7), 32'd0);
      end else begin
        e = rate7_q.pop_front();
        check("rate7_out", 32'(rate_out7), e.val);
        check("rate7_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (isi_mon && (isi_valid === 1'b1)) begin
      if (isi_q.size() == 0) begin
        check("isi_valid_unexpected", 32'(isi_valid), 32'd0);
      end else begin
        e = isi_q.pop_front();
        check("isi_out", 32'(isi_out), e.val);
        check("isi_cycle", cyc, e.cyc);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Vector tables
  // ---------------------------------------------------------------------
  typedef struct {
    int          len;
    logic [31:0] pat;   // bit c = spike_in level in window cycle c
    int          exp;
  } win_vec_t;

  typedef struct {
    int at;             // cycle of the onset
    int exp;            // expected isi_out
    bit has;            // onset produces an isi_valid pulse
  } isi_vec_t;

  win_vec_t wv[9];
  isi_vec_t iv[7];

  initial begin
    // Back-to-back windows; each entry programs the next length mid-window.
    wv[0] = '{10, 32'h0000_0209, 3};  // spikes at 0,3,9
    wv[1] = '{10, 32'h0000_0000, 0};  // spike-free
    wv[2] = '{20, 32'h0000_07E0, 1};  // level held for 6 cycles
    wv[3] = '{10, 32'h0000_00A6, 3};  // len 10->5 requested mid-window
    wv[4] = '{5,  32'h0000_0015, 3};  // onset on the closing cycle
    wv[5] = '{4,  32'h0000_0001, 0};  // level carried over the boundary
    wv[6] = '{1,  32'h0000_0001, 1};  // single-cycle window
    wv[7] = '{1,  32'h0000_0000, 0};
    wv[8] = '{2,  32'h0000_0002, 1};

    iv[0] = '{4,   0,   1'b0};        // first onset only arms
    iv[1] = '{11,  7,   1'b1};
    iv[2] = '{13,  2,   1'b1};
    iv[3] = '{15,  2,   1'b1};
    iv[4] = '{17,  2,   1'b1};
    iv[5] = '{317, 255, 1'b1};        // 300-cycle gap saturates
    iv[6] = '{319, 2,   1'b1};

    // --- reset state ---
    rst_n      = 1'b1;
    en         = 1'b0;
    en7        = 1'b0;
    spike_in   = 1'b0;
    window_len = 8'd0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_rate_out",   32'(rate_out),   32'd0);
    check("rst_rate_valid", 32'(rate_valid), 32'd0);
    check("rst_isi_out",    32'(isi_out),    32'd0);
    check("rst_isi_valid",  32'(isi_valid),  32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    #9 rst_n = 1'b1;
    step();

    // --- window table ---
    en         = 1'b1;
    window_len = 8'(wv[0].len);
    @(negedge clk);
    check("busy_before_entry", 32'(busy), 32'd0);
    step();
    @(negedge clk);
    check("busy_after_entry", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    // The extra cycle above was the first window cycle; restart cleanly by
    // dropping en so the table starts on a fresh window.
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      for (int c = 0; c < wv[i].len; c++) begin
        spike_in = wv[i].pat[c];
        if (c == wv[i].len / 2) window_len = (i == 8) ? 8'd0 : 8'(wv[i + 1].len);
        if (c == wv[i].len - 1) rate_q.push_back('{wv[i].exp, cyc + 1});
        step();
      end
    end
    spike_in = 1'b0;
    @(negedge clk);
    check("busy_after_len0", 32'(busy), 32'd0);
    step();

    // --- disable mid-window ---
    window_len = 8'd10;
    step();
    for (int c = 0; c < 4; c++) begin
      spike_in = (c == 1);
      step();
    end
    spike_in = 1'b0;
    en       = 1'b0;
    @(negedge clk);
    check("busy_en_drop_cycle", 32'(busy), 32'd1);
    step();
    @(negedge clk);
    check("busy_fall", 32'(busy), 32'd0);
    for (int c = 0; c < 15; c++) step();

    // --- reset mid-window ---
    en         = 1'b1;
    window_len = 8'd10;
    step();
    for (int c = 0; c < 5; c++) begin
      spike_in = (c == 2);
      step();
    end
    spike_in = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_rate_out",   32'(rate_out),   32'd0);
    check("midrst_rate_valid", 32'(rate_valid), 32'd0);
    check("midrst_isi_out",    32'(isi_out),    32'd0);
    check("midrst_isi_valid",  32'(isi_valid),  32'd0);
    check("midrst_busy",       32'(busy),       32'd0);
    #1 rst_n = 1'b1;
    step();
    for (int c = 0; c < 10; c++) begin
      spike_in = (c == 6);
      if (c == 5) window_len = 8'd0;
      if (c == 9) rate_q.push_back('{1, cyc + 1});
      step();
    end
    spike_in = 1'b0;

    // --- ISI ---
    en = 1'b0;
    step();
    en      = 1'b1;
    isi_mon = 1'b1;
    begin
      int k = 0;
      for (int r = 0; r < 326; r++) begin
        spike_in = 1'b0;
        if ((k < 7) && (r == iv[k].at)) begin
          spike_in = 1'b1;
          if (iv[k].has) isi_q.push_back('{iv[k].exp, cyc + 1});
          k++;
        end
        step();
      end
    end
    spike_in = 1'b0;
    en       = 1'b0;
    step();
    en = 1'b1;
    for (int r = 0; r < 10; r++) begin
      spike_in = (r == 2) || (r == 7);
      if (r == 7) isi_q.push_back('{5, cyc + 1});
      step();
    end
    spike_in = 1'b0;
    isi_mon  = 1'b0;

    // --- rate saturation: 128 onsets in a 255-cycle window ---
    en7        = 1'b1;
    window_len = 8'd255;
    step();
    for (int c = 0; c < 255; c++) begin
      spike_in = ((c % 2) == 0);
      if (c == 127) window_len = 8'd0;
      if (c == 254) begin
        rate_q.push_back('{128, cyc + 1});
        rate7_q.push_back('{127, cyc + 1});
      end
      step();
    end
    spike_in = 1'b0;
    for (int c = 0; c < 3; c++) step();
    @(negedge clk);
    check("sat_busy",       32'(busy),       32'd0);
    check("sat_busy7",      32'(busy7),      32'd0);
    check("sat_isi7_alt",   32'(isi_out7),   32'd2);
    check("sat_isi7_valid", 32'(isi_valid7), 32'd0);

    // --- every queued expectation must have been met ---
    check("rate_q_drained",  rate_q.size(),  32'd0);
    check("rate7_q_drained", rate7_q.size(), 32'd0);
    check("isi_q_drained",   isi_q.size(),   32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
